// File: rtl/div_pkg.sv
// Shared constants for the divide sign-control stage: FSM encoding, default width,
// divide-by-zero quotient pattern and settle-counter sizing.
package div_pkg;

  localparam int DEFAULT_REG_SIZE = 32;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_FIX    = 2'd2;

  localparam logic [DEFAULT_REG_SIZE-1:0] DBZ_QUOTIENT = '1;

  function automatic int cnt_width(input int settle_cycles);
    return $clog2(settle_cycles) + 1;
  endfunction

endpackage

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negate, used both to form operand magnitudes
// and to restore the sign of quotient/remainder.
module div_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] value,
  input  logic         neg,
  output logic [W-1:0] result
);

  // Wraps at W bits, so the most negative value maps to itself.
  assign result = neg ? (~value + W'(1)) : value;

endmodule

// File: rtl/div_sign_ctrl.sv
// Control and sign handling around an unsigned combinational divider core.
// Optional divide-by-zero trap enabled by defining DIV_ZERO_TRAP_EN.
module div_sign_ctrl
  import div_pkg::*;
#(
  parameter int REG_SIZE      = DEFAULT_REG_SIZE,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  start,
  input  logic                  is_signed,
  input  logic [REG_SIZE-1:0]   dividend,
  input  logic [REG_SIZE-1:0]   divisor,
  output logic [REG_SIZE-1:0]   core_dividend,
  output logic [REG_SIZE-1:0]   core_divisor,
  input  logic [2*REG_SIZE-1:0] core_z,
  output logic [REG_SIZE-1:0]   hi,
  output logic [REG_SIZE-1:0]   lo,
  output logic                  busy,
  output logic                  done,
  output logic                  dbz
);

  localparam int             CW       = cnt_width(SETTLE_CYCLES);
  localparam logic [CW-1:0]  CNT_LOAD = CW'(SETTLE_CYCLES - 1);

  logic [1:0]          state;
  logic [CW-1:0]       cnt;
  logic                neg_q;
  logic                neg_r;
  logic                neg_dd;
  logic                neg_dv;
  logic                zero_div;
  logic [REG_SIZE-1:0] mag_dd;
  logic [REG_SIZE-1:0] mag_dv;
  logic [REG_SIZE-1:0] hi_src;
  logic [REG_SIZE-1:0] hi_fix;
  logic [REG_SIZE-1:0] lo_fix;
  logic [REG_SIZE-1:0] lo_next;

  assign neg_dd = is_signed & dividend[REG_SIZE-1];
  assign neg_dv = is_signed & divisor[REG_SIZE-1];
  assign busy   = (state != ST_IDLE);

  div_sign_fix #(.W(REG_SIZE)) u_mag_dd (.value(dividend), .neg(neg_dd), .result(mag_dd));
  div_sign_fix #(.W(REG_SIZE)) u_mag_dv (.value(divisor),  .neg(neg_dv), .result(mag_dv));
  div_sign_fix #(.W(REG_SIZE)) u_fix_lo (.value(core_z[REG_SIZE-1:0]), .neg(neg_q), .result(lo_fix));
  div_sign_fix #(.W(REG_SIZE)) u_fix_hi (.value(hi_src), .neg(neg_r), .result(hi_fix));

`ifdef DIV_ZERO_TRAP_EN
  logic dbz_q;

  // Re-signing the stored dividend magnitude recovers the raw dividend for hi.
  assign zero_div = (divisor == '0);
  assign hi_src   = dbz_q ? core_dividend : core_z[2*REG_SIZE-1:REG_SIZE];
  assign lo_next  = dbz_q ? {REG_SIZE{DBZ_QUOTIENT[0]}} : lo_fix;
  assign dbz      = dbz_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      dbz_q <= 1'b0;
    end else if (state == ST_IDLE && start) begin
      dbz_q <= zero_div;
    end
  end
`else
  assign zero_div = 1'b0;
  assign hi_src   = core_z[2*REG_SIZE-1:REG_SIZE];
  assign lo_next  = lo_fix;
  assign dbz      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (clr) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      neg_q         <= 1'b0;
      neg_r         <= 1'b0;
      core_dividend <= '0;
      core_divisor  <= '0;
      hi            <= '0;
      lo            <= '0;
      done          <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            neg_q         <= is_signed & (dividend[REG_SIZE-1] ^ divisor[REG_SIZE-1]);
            neg_r         <= neg_dd;
            core_dividend <= mag_dd;
            core_divisor  <= mag_dv;
            cnt           <= CNT_LOAD;
            state         <= zero_div ? ST_FIX : ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (cnt == '0) begin
            state <= ST_FIX;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_FIX: begin
          lo    <= lo_next;
          hi    <= hi_fix;
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_sign_ctrl.sv
// Self-checking bench for div_sign_ctrl with a behavioural divider core stub;
// expectations follow DIV_ZERO_TRAP_EN when it is defined for the build.
module tb_div_sign_ctrl;

  localparam int R      = 32;
  localparam int SETTLE = 2;

  logic           clk = 1'b0;
  logic           clr;
  logic           start;
  logic           is_signed;
  logic [R-1:0]   dividend;
  logic [R-1:0]   divisor;
  logic [R-1:0]   core_dividend;
  logic [R-1:0]   core_divisor;
  logic [2*R-1:0] core_z;
  logic [R-1:0]   hi;
  logic [R-1:0]   lo;
  logic           busy;
  logic           done;
  logic           dbz;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Unsigned core stand-in: zero divisor yields quotient 0, remainder = dividend.
  always_comb begin
    core_z = '0;
    if (core_divisor == '0) core_z = {core_dividend, {R{1'b0}}};
    else                    core_z = {core_dividend % core_divisor, core_dividend / core_divisor};
  end

  div_sign_ctrl #(.REG_SIZE(R), .SETTLE_CYCLES(SETTLE)) dut (
    .clk(clk), .clr(clr), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor),
    .core_dividend(core_dividend), .core_divisor(core_divisor), .core_z(core_z),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .dbz(dbz)
  );

  // Truncating division worked in 64-bit arithmetic so the -2^31 / -1 case wraps cleanly.
  function automatic void ref_div(input bit s, input logic [R-1:0] a, input logic [R-1:0] b,
                                  output logic [R-1:0] q, output logic [R-1:0] r,
                                  output logic z, output int lat);
    longint sa, sb;
    z   = 1'b0;
    lat = SETTLE + 2;
    if (b == 0) begin
`ifdef DIV_ZERO_TRAP_EN
      q = '1; r = a; z = 1'b1; lat = 2;
`else
      q = '0; r = a;
`endif
    end else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = R'(sa / sb);
      r  = R'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  task automatic checkOutput(input string tag, input logic [R-1:0] obs, input logic [R-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request at the current negedge, wait for done, check result and latency.
  task automatic applyStimulus(input bit s, input logic [R-1:0] a, input logic [R-1:0] b,
                               input bit back_to_back);
    logic [R-1:0] eq, er;
    logic         ez;
    int           lat, k;
    ref_div(s, a, b, eq, er, ez, lat);
    is_signed = s; dividend = a; divisor = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 1;
    while (done !== 1'b1 && k < 40) begin
      checkOutput("busy_during_op", {31'b0, busy}, 1);
      @(negedge clk);
      k++;
    end
    checkOutput("latency", k, lat);
    checkOutput("done", {31'b0, done}, 1);
    checkOutput("busy_at_done", {31'b0, busy}, 0);
    checkOutput("lo", lo, eq);
    checkOutput("hi", hi, er);
    checkOutput("dbz", {31'b0, dbz}, {31'b0, ez});
    if (!back_to_back) begin
      @(negedge clk);
      checkOutput("done_one_cycle", {31'b0, done}, 0);
    end
  endtask

  initial begin
    int dones;
    clr = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_hi", hi, 0);
    checkOutput("rst_lo", lo, 0);
    checkOutput("rst_busy", {31'b0, busy}, 0);
    checkOutput("rst_done", {31'b0, done}, 0);
    checkOutput("rst_dbz", {31'b0, dbz}, 0);
    checkOutput("rst_core_dd", core_dividend, 0);
    checkOutput("rst_core_dv", core_divisor, 0);
    clr = 1'b0;
    @(negedge clk);

    applyStimulus(1'b1, 32'd100, 32'd7, 1'b0);
    applyStimulus(1'b1, -32'sd100, 32'd7, 1'b0);
    applyStimulus(1'b1, 32'd100, -32'sd7, 1'b0);
    applyStimulus(1'b1, -32'sd100, -32'sd7, 1'b0);
    applyStimulus(1'b0, 32'hFFFF_FFFF, 32'd2, 1'b0);
    applyStimulus(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    applyStimulus(1'b0, 32'd55, 32'd0, 1'b0);
    applyStimulus(1'b1, -32'sd55, 32'd0, 1'b0);
    applyStimulus(1'b0, 32'd9, 32'd3, 1'b0);

    // Start issued in the done cycle must be accepted.
    applyStimulus(1'b1, 32'd77, 32'd5, 1'b1);
    applyStimulus(1'b0, 32'd1234, 32'd10, 1'b0);

    // A second start while busy is dropped; only the first result appears.
    is_signed = 1'b1; dividend = 32'd1000; divisor = 32'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    dividend = 32'd5; divisor = 32'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      if (done === 1'b1) begin
        dones++;
        checkOutput("ignored_lo", lo, 32'd111);
        checkOutput("ignored_hi", hi, 32'd1);
      end
      @(negedge clk);
    end
    checkOutput("ignored_single_done", dones, 1);

    // Reset in the settle window aborts the operation.
    is_signed = 1'b0; dividend = 32'd500; divisor = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0; clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    checkOutput("abort_busy", {31'b0, busy}, 0);
    checkOutput("abort_hi", hi, 0);
    checkOutput("abort_lo", lo, 0);
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      if (done === 1'b1) dones++;
      @(negedge clk);
    end
    checkOutput("abort_no_done", dones, 0);

    for (int i = 0; i < 40; i++) begin
      logic [R-1:0] a, b;
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = $urandom_range(1, 20);
        1:       b = -$urandom_range(1, 20);
        2:       b = (i % 8 == 0) ? '0 : $urandom;
        default: b = $urandom;
      endcase
      applyStimulus(1'($urandom_range(0, 1)), a, b, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
